multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control FSM for the multi-cycle MIPS datapath. The block sequences one instruction through fetch, decode, execute, memory and write-back over 3–5 cycles. Each cycle it drives the datapath mux selects, the register, IR, PC and memory enables, and the 4-bit ALUOp consumed by the ALU controller. A single-port unified memory with a ready handshake is shared between instruction fetch and data access.

## Interface
- No parameters.
- clk_i  in  1  system clock, rising-edge.
- rst_i  in  1  asynchronous, active-low reset.
- opcode_i  in  6  IR[31:26]; stable outside FETCH.
- mem_ready_i  in  1  memory completes the current access this cycle.
- PCWrite_o  out  1  unconditional PC load.
- PCWriteCond_o  out  1  PC load if ALU zero.
- IorD_o  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory.
- MemRead_o, MemWrite_o  out  1 each  memory strobes.
- IRWrite_o  out  1  IR load.
- MemtoReg_o  out  1  write-back data: 1 = MDR, 0 = ALUOut.
- RegDst_o  out  1  destination register: 1 = rd, 0 = rt.
- RegWrite_o  out  1  register file write.
- ALUSrcA_o  out  1  ALU A operand: 0 = PC, 1 = A.
- ALUSrcB_o  out  2  ALU B operand: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- PCSource_o  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- ALUOp_o  out  4  ALUOp encodings: 0000 = R-type (use funct), 1000 = add, 0100 = sub, 1010 = slt.
- state_o  out  4  current state, for debug.
- illegal_o  out  1  unsupported-opcode pulse.

## Operation
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, IMMEX 9, IMMWB 10, JUMP 11. Codes 12–15 go to FETCH on the next edge.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, slti 001010, j 000010.
- Outputs are Moore decodes of the state, except for the mem_ready_i gating noted below. Any output not listed for a state is 0, including ALUOp_o = 0000 and all selects = 0.

Per-state outputs and transitions:
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=1000, PCSource=00.
  - IRWrite and PCWrite are 1 only when mem_ready_i=1.
  - Holds in FETCH while mem_ready_i=0; goes to DECODE when ready.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=1000 (precomputes the branch target).
  - Next state: lw/sw → MEMADR; R-type → EXEC; beq → BRANCH; addi/slti → IMMEX; j → JUMP.
  - Any other opcode → FETCH with illegal_o=1 for that one cycle.
- MEMADR:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=1000.
  - Next state: lw → MEMRD; sw → MEMWR.
- MEMRD:
  - Outputs: MemRead=1, IorD=1.
  - Holds until mem_ready_i=1, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; → FETCH.
- MEMWR:
  - Outputs: IorD=1; MemWrite=1 every cycle in the state.
  - Holds until mem_ready_i=1, then goes to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=0000; → ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0; → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=0100, PCWriteCond=1, PCSource=01; → FETCH.
- IMMEX:
  - Outputs: ALUSrcA=1, ALUSrcB=10.
  - ALUOp=1000 for addi, 1010 for slti, decoded from opcode_i.
  - Next state: IMMWB.
- IMMWB: RegWrite=1, RegDst=0, MemtoReg=0; → FETCH.
- JUMP: PCWrite=1, PCSource=10; → FETCH.

## Timing
- While rst_i=0:
  - State is FETCH.
  - All write enables are forced to 0: PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite.
  - illegal_o=0.
  - Other outputs show FETCH values (MemRead=1, ALUSrcB=01, ALUOp=1000).
- Reset is asynchronous: asserting rst_i mid-instruction returns the FSM to FETCH immediately and drops all enables in the same cycle.
- The first rising edge after rst_i deasserts evaluates FETCH normally.
- Cycles per instruction with zero-wait memory (mem_ready_i tied to 1):
  - beq, j: 3
  - R-type, addi, slti, sw: 4
  - lw: 5
- Each memory wait cycle adds 1 cycle, in FETCH, MEMRD or MEMWR.
- mem_ready_i is sampled only in FETCH, MEMRD and MEMWR; it is ignored elsewhere.
- A request must not be reissued: exactly one IRWrite/PCWrite pulse occurs per FETCH exit.
- opcode_i is sampled in DECODE, MEMADR and IMMEX. The IR changes only on an IRWrite cycle, so the value is constant within an instruction.

## Test plan
- Zero-wait sequence R-type, lw, sw, beq, addi, j from reset:
  - state_o visits 0,1,6,7 / 0,1,2,3,4 / 0,1,2,5 / 0,1,8 / 0,1,9,10 / 0,1,11.
  - Total of 23 cycles; RegWrite pulses exactly 3 times.
- lw with mem_ready_i=0 for 2 cycles in FETCH and 3 cycles in MEMRD:
  - The instruction takes 10 cycles.
  - IRWrite and PCWrite are high only on the ready cycle.
  - MemRead stays high throughout both waits.
- slti vs addi in IMMEX: ALUOp_o=1010 for slti and 1000 for addi; ALUSrcB_o=10 in both.
- Opcode 111111: DECODE asserts illegal_o for 1 cycle; the next state is FETCH and no enables assert.
- Reset asserted in MEMWR while MemWrite=1:
  - MemWrite drops to 0 asynchronously in the same cycle and state_o=0.
  - After release, the next instruction fetch is normal.
- beq: in BRANCH, PCWriteCond=1, ALUOp=0100, PCSource=01 and PCWrite=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath. Sequences one
// instruction through fetch/decode/execute/memory/write-back and drives the
// datapath selects and enables as Moore decodes of the current state. The
// only input-dependent outputs are the fetch-complete strobes (gated by
// mem_ready_i), the IMMEX ALUOp (addi vs slti) and the DECODE illegal pulse.
module multicycle_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output logic       PCWrite_o,
  output logic       PCWriteCond_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       MemtoReg_o,
  output logic       RegDst_o,
  output logic       RegWrite_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [1:0] PCSource_o,
  output logic [3:0] ALUOp_o,
  output logic [3:0] state_o,
  output logic       illegal_o
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
    BRANCH = 4'd8,  IMMEX  = 4'd9,  IMMWB  = 4'd10, JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] ALU_FUNCT = 4'b0000;
  localparam logic [3:0] ALU_ADD   = 4'b1000;
  localparam logic [3:0] ALU_SUB   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b1010;

  state_e state_q, state_d;
  logic   illegal_d;

  // State register; reset drops straight back to FETCH without waiting for a clock.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic; mem_ready_i only matters in the three memory-access states.
  always_comb begin
    state_d   = FETCH;
    illegal_d = 1'b0;
    case (state_q)
      FETCH:  state_d = mem_ready_i ? DECODE : FETCH;
      DECODE: begin
        case (opcode_i)
          OP_LW, OP_SW:     state_d = MEMADR;
          OP_RTYPE:         state_d = EXEC;
          OP_BEQ:           state_d = BRANCH;
          OP_ADDI, OP_SLTI: state_d = IMMEX;
          OP_J:             state_d = JUMP;
          default: begin
            state_d   = FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEMADR: state_d = (opcode_i == OP_LW) ? MEMRD :
                        (opcode_i == OP_SW) ? MEMWR : FETCH;
      MEMRD:  state_d = mem_ready_i ? MEMWB : MEMRD;
      MEMWR:  state_d = mem_ready_i ? FETCH : MEMWR;
      EXEC:   state_d = ALUWB;
      IMMEX:  state_d = IMMWB;
      default: state_d = FETCH;   // write-back, branch, jump and unused codes 12-15
    endcase
  end

  // Output decode; every write enable is additionally gated by rst_i so that
  // asserting reset kills the enables combinationally in the same cycle.
  always_comb begin
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    IorD_o        = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    IRWrite_o     = 1'b0;
    MemtoReg_o    = 1'b0;
    RegDst_o      = 1'b0;
    RegWrite_o    = 1'b0;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = 2'b00;
    PCSource_o    = 2'b00;
    ALUOp_o       = ALU_FUNCT;
    case (state_q)
      FETCH: begin
        MemRead_o = 1'b1;
        ALUSrcB_o = 2'b01;
        ALUOp_o   = ALU_ADD;
        // one IR/PC load per fetch, on the cycle the memory delivers
        IRWrite_o = mem_ready_i & rst_i;
        PCWrite_o = mem_ready_i & rst_i;
      end
      DECODE: begin
        ALUSrcB_o = 2'b11;
        ALUOp_o   = ALU_ADD;
      end
      MEMADR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
        ALUOp_o   = ALU_ADD;
      end
      MEMRD: begin
        MemRead_o = 1'b1;
        IorD_o    = 1'b1;
      end
      MEMWB: begin
        RegWrite_o = rst_i;
        MemtoReg_o = 1'b1;
      end
      MEMWR: begin
        IorD_o     = 1'b1;
        MemWrite_o = rst_i;
      end
      EXEC: ALUSrcA_o = 1'b1;
      ALUWB: begin
        RegWrite_o = rst_i;
        RegDst_o   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA_o     = 1'b1;
        ALUOp_o       = ALU_SUB;
        PCWriteCond_o = rst_i;
        PCSource_o    = 2'b01;
      end
      IMMEX: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
        ALUOp_o   = (opcode_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      IMMWB: RegWrite_o = rst_i;
      JUMP: begin
        PCWrite_o  = rst_i;
        PCSource_o = 2'b10;
      end
      default: ;
    endcase
  end

  assign illegal_o = illegal_d & rst_i;
  assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: inputs change 1ns after the rising
// edge, outputs are sampled a further 1ns later, well away from the edge.
module tb_multicycle_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] opcode_i;
  logic       mem_ready_i;
  logic       PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o;
  logic       MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, illegal_o;
  logic [1:0] ALUSrcB_o, PCSource_o;
  logic [3:0] ALUOp_o, state_o;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, SLTI = 6'b001010, JMP = 6'b000010;

  multicycle_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .mem_ready_i(mem_ready_i),
    .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .IorD_o(IorD_o),
    .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .IRWrite_o(IRWrite_o),
    .MemtoReg_o(MemtoReg_o), .RegDst_o(RegDst_o), .RegWrite_o(RegWrite_o),
    .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .PCSource_o(PCSource_o),
    .ALUOp_o(ALUOp_o), .state_o(state_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; mem_ready_i = 1'b1; opcode_i = RT;
    #2 rst_i = 1'b0;
    tick(); tick(); #1;
    checks++;
    if (state_o !== 4'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_o); end
    checks++;
    if ({PCWrite_o, PCWriteCond_o, IRWrite_o, RegWrite_o, MemWrite_o, illegal_o} !== 6'b0) begin
      errors++; $display("FAIL reset_enables got %b exp 000000",
        {PCWrite_o, PCWriteCond_o, IRWrite_o, RegWrite_o, MemWrite_o, illegal_o});
    end
    checks++;
    if ({MemRead_o, ALUSrcB_o, ALUOp_o} !== 7'b1_01_1000) begin
      errors++; $display("FAIL reset_fetch_vals got %b exp 1011000", {MemRead_o, ALUSrcB_o, ALUOp_o});
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if ({IRWrite_o, PCWrite_o} !== 2'b11) begin
      errors++; $display("FAIL release_fetch_strobes got %b exp 11", {IRWrite_o, PCWrite_o});
    end
    tick();
    checks++;
    if (state_o !== 4'd1) begin errors++; $display("FAIL first_edge_state got %0d exp 1", state_o); end
    tick(); tick(); tick();   // R-type: EXEC, ALUWB, back to FETCH
    checks++;
    if (state_o !== 4'd0) begin errors++; $display("FAIL after_rtype_state got %0d exp 0", state_o); end
  endtask

  task automatic test_zero_wait_seq();
    logic [3:0] exp_st [23];
    logic [5:0] ops [6];
    int k = 0;
    int rw = 0;
    exp_st = '{4'd0,4'd1,4'd6,4'd7, 4'd0,4'd1,4'd2,4'd3,4'd4, 4'd0,4'd1,4'd2,4'd5,
               4'd0,4'd1,4'd8, 4'd0,4'd1,4'd9,4'd10, 4'd0,4'd1,4'd11};
    ops = '{RT, LW, SW, BEQ, ADDI, JMP};
    rst_i = 1'b0; #1; rst_i = 1'b1; mem_ready_i = 1'b1;
    for (int i = 0; i < 23; i++) begin
      if (exp_st[i] == 4'd0) begin opcode_i = ops[k]; k++; end
      #1;
      checks++;
      if (state_o !== exp_st[i]) begin
        errors++; $display("FAIL seq_state cycle %0d got %0d exp %0d", i, state_o, exp_st[i]);
      end
      if (RegWrite_o === 1'b1) rw++;
      tick();
    end
    checks++;
    if (state_o !== 4'd0) begin errors++; $display("FAIL seq_end_state got %0d exp 0", state_o); end
    checks++;
    if (rw != 3) begin errors++; $display("FAIL seq_regwrite_count got %0d exp 3", rw); end
  endtask

  task automatic test_lw_waits();
    logic [3:0] st  [10];
    logic       rdy [10];
    logic       irw [10];
    logic       mr  [10];
    st  = '{4'd0,4'd0,4'd0,4'd1,4'd2,4'd3,4'd3,4'd3,4'd3,4'd4};
    rdy = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
    irw = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    mr  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b0};
    opcode_i = LW;
    for (int i = 0; i < 10; i++) begin
      mem_ready_i = rdy[i];
      #1;
      checks++;
      if (state_o !== st[i] || IRWrite_o !== irw[i] || PCWrite_o !== irw[i] || MemRead_o !== mr[i]) begin
        errors++; $display("FAIL lw_wait cycle %0d got st=%0d ir=%b pc=%b mr=%b exp st=%0d ir=%b pc=%b mr=%b",
          i, state_o, IRWrite_o, PCWrite_o, MemRead_o, st[i], irw[i], irw[i], mr[i]);
      end
      tick();
    end
    mem_ready_i = 1'b1;
    #1;
    checks++;
    if (state_o !== 4'd0) begin errors++; $display("FAIL lw_wait_end got %0d exp 0", state_o); end
  endtask

  task automatic test_imm_aluop();
    logic [5:0] op [2];
    logic [3:0] ex [2];
    op = '{ADDI, SLTI};
    ex = '{4'b1000, 4'b1010};
    for (int i = 0; i < 2; i++) begin
      opcode_i = op[i]; mem_ready_i = 1'b1;
      tick(); tick();
      checks++;
      if (state_o !== 4'd9 || ALUOp_o !== ex[i] || ALUSrcB_o !== 2'b10 || ALUSrcA_o !== 1'b1) begin
        errors++; $display("FAIL immex_%0d got st=%0d op=%b srcb=%b srca=%b exp st=9 op=%b srcb=10 srca=1",
          i, state_o, ALUOp_o, ALUSrcB_o, ALUSrcA_o, ex[i]);
      end
      tick(); tick();
    end
  endtask

  task automatic test_illegal();
    opcode_i = 6'b111111; mem_ready_i = 1'b1;
    tick();
    checks++;
    if (state_o !== 4'd1 || illegal_o !== 1'b1) begin
      errors++; $display("FAIL illegal_decode got st=%0d ill=%b exp st=1 ill=1", state_o, illegal_o);
    end
    checks++;
    if ({PCWrite_o, PCWriteCond_o, IRWrite_o, RegWrite_o, MemWrite_o, MemRead_o} !== 6'b0) begin
      errors++; $display("FAIL illegal_enables got %b exp 000000",
        {PCWrite_o, PCWriteCond_o, IRWrite_o, RegWrite_o, MemWrite_o, MemRead_o});
    end
    tick();
    checks++;
    if (state_o !== 4'd0 || illegal_o !== 1'b0) begin
      errors++; $display("FAIL illegal_next got st=%0d ill=%b exp st=0 ill=0", state_o, illegal_o);
    end
  endtask

  task automatic test_reset_in_memwr();
    opcode_i = SW; mem_ready_i = 1'b1;
    tick(); tick();
    mem_ready_i = 1'b0;
    tick();
    #1;
    checks++;
    if (state_o !== 4'd5 || MemWrite_o !== 1'b1 || IorD_o !== 1'b1) begin
      errors++; $display("FAIL memwr_active got st=%0d mw=%b iord=%b exp st=5 mw=1 iord=1", state_o, MemWrite_o, IorD_o);
    end
    #1 rst_i = 1'b0;
    #1;
    checks++;
    if (state_o !== 4'd0 || MemWrite_o !== 1'b0) begin
      errors++; $display("FAIL async_reset got st=%0d mw=%b exp st=0 mw=0", state_o, MemWrite_o);
    end
    tick();
    rst_i = 1'b1; mem_ready_i = 1'b1; opcode_i = RT;
    #1;
    checks++;
    if (IRWrite_o !== 1'b1 || MemRead_o !== 1'b1 || IorD_o !== 1'b0) begin
      errors++; $display("FAIL refetch got ir=%b mr=%b iord=%b exp ir=1 mr=1 iord=0", IRWrite_o, MemRead_o, IorD_o);
    end
    tick();
    checks++;
    if (state_o !== 4'd1) begin errors++; $display("FAIL refetch_decode got %0d exp 1", state_o); end
    tick(); tick(); tick();
  endtask

  task automatic test_beq();
    opcode_i = BEQ; mem_ready_i = 1'b1;
    tick(); tick();
    checks++;
    if (state_o !== 4'd8 || PCWriteCond_o !== 1'b1 || ALUOp_o !== 4'b0100 ||
        PCSource_o !== 2'b01 || PCWrite_o !== 1'b0 || ALUSrcA_o !== 1'b1 || ALUSrcB_o !== 2'b00) begin
      errors++; $display("FAIL beq_branch got st=%0d pwc=%b op=%b psrc=%b pw=%b srca=%b srcb=%b exp 8 1 0100 01 0 1 00",
        state_o, PCWriteCond_o, ALUOp_o, PCSource_o, PCWrite_o, ALUSrcA_o, ALUSrcB_o);
    end
    tick();
    checks++;
    if (state_o !== 4'd0) begin errors++; $display("FAIL beq_return got %0d exp 0", state_o); end
  endtask

  initial begin
    test_reset();
    test_zero_wait_seq();
    test_lw_waits();
    test_imm_aluop();
    test_illegal();
    test_reset_in_memwr();
    test_beq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
